// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
//    Shares one single-port unified instruction/data memory between the IF
//    stage (read-only fetch) and the MEM stage (load/store). Each access is a
//    req/ack handshake to a variable-latency memory; the completion is
//    reported to the owner as a one-cycle valid pulse one cycle after mem_ack.
//    When both sides keep requesting, grants alternate so neither starves.
//
// Optional build macro: ARB_TIMEOUT_EN
//    Adds a per-access watchdog. After TIMEOUT cycles in BUSY without mem_ack
//    the access is ended, the owner gets rdata = all ones, and arb_err is set
//    until reset. Without the macro BUSY waits indefinitely and arb_err = 0.
//
// Ports
//    clk, rst          clock (rising edge), asynchronous active-low reset
//    if_req/if_addr    fetch request and PC, held until if_valid or if_abort
//    if_abort          pipeline flush, cancels a pending or in-flight fetch
//    if_rdata/if_valid registered instruction and its one-cycle valid pulse
//    if_stall          if_req & ~if_valid
//    dm_req/dm_we/dm_addr/dm_wdata  data request, held until dm_valid
//    dm_rdata/dm_valid registered load data and completion pulse
//    dm_stall          dm_req & ~dm_valid
//    mem_req/mem_we/mem_addr/mem_wdata  registered memory request
//    mem_rdata/mem_ack memory read data and one-cycle acknowledge
//    arb_err           sticky watchdog timeout flag

module unified_mem_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   input  logic          if_abort,
   output logic [DW-1:0] if_rdata,
   output logic          if_valid,
   output logic          if_stall,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic [DW-1:0] dm_rdata,
   output logic          dm_valid,
   output logic          dm_stall,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack,
   output logic          arb_err
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        state, state_next;
   logic          owner_dm;
   logic          last_dm;
   logic          aborted;
   logic          grant_dm, grant_if;
   logic          timed_out;
   logic          finish;
   logic [DW-1:0] rdata_in;

   assign if_stall = if_req & ~if_valid;
   assign dm_stall = dm_req & ~dm_valid;

   // An access ends on mem_ack; mem_ack outside BUSY has no effect.
   assign finish   = (state == BUSY) && (mem_ack || timed_out);
   assign rdata_in = timed_out ? {DW{1'b1}} : mem_rdata;

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

   logic [CW-1:0] wd_count;
   logic          err_q;

   // Held at zero outside BUSY, so every access starts counting from zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                 wd_count <= '0;
      else if (state != BUSY)   wd_count <= '0;
      else if (wd_count != TMAX) wd_count <= wd_count + 1'b1;
   end

   assign timed_out = (state == BUSY) && !mem_ack && (wd_count == TMAX);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)           err_q <= 1'b0;
      else if (timed_out) err_q <= 1'b1;
   end

   assign arb_err = err_q;
`else
   // No watchdog: this term is constant false and only keeps TIMEOUT in use.
   assign timed_out = (TIMEOUT < 0);
   assign arb_err   = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // DM wins unless IF is also waiting and DM had the previous grant; this
   // gives strict alternation when both keep requesting. An abort in IDLE
   // blocks the fetch grant for that cycle.
   always_comb begin
      state_next = state;
      grant_dm   = 1'b0;
      grant_if   = 1'b0;
      case (state)
         IDLE: begin
            grant_dm = dm_req && (!if_req || !last_dm);
            grant_if = !grant_dm && if_req && !if_abort;
            if (grant_dm || grant_if) state_next = BUSY;
         end
         BUSY:    if (finish) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // A flushed fetch still has to finish its memory cycle, but its result is
   // dropped: the abort is remembered until the ack so if_rdata keeps its
   // previous instruction and no if_valid is produced.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
         if_valid  <= 1'b0;
         dm_valid  <= 1'b0;
         owner_dm  <= 1'b0;
         last_dm   <= 1'b0;
         aborted   <= 1'b0;
      end else begin
         if_valid <= 1'b0;
         dm_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_dm || grant_if) begin
                  owner_dm  <= grant_dm;
                  last_dm   <= grant_dm;
                  aborted   <= 1'b0;
                  mem_req   <= 1'b1;
                  mem_we    <= grant_dm && dm_we;
                  mem_addr  <= grant_dm ? dm_addr : if_addr;
                  mem_wdata <= grant_dm ? dm_wdata : '0;
               end
            end
            BUSY: begin
               if (!owner_dm && if_abort) aborted <= 1'b1;
               if (finish) begin
                  mem_req <= 1'b0;
                  if (owner_dm) begin
                     dm_valid <= 1'b1;
                     dm_rdata <= rdata_in;
                  end else if (!(aborted || if_abort)) begin
                     if_valid <= 1'b1;
                     if_rdata <= rdata_in;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_abort, dm_req, dm_we, mem_ack;
   logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
   logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
   logic        if_valid, if_stall, dm_valid, dm_stall, mem_req, mem_we, arb_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   unified_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(15)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_abort(if_abort),
      .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .arb_err(arb_err)
   );

   // Memory environment: acks mem_delay cycles after mem_req is first seen,
   // drives random garbage on mem_rdata whenever it is not acking.
   logic [31:0] mem_model [logic [31:0]];
   logic [31:0] ref_mem   [logic [31:0]];
   int mem_delay      = 0;
   bit mem_rand_delay = 1'b0;
   bit mem_silent     = 1'b0;
   int wait_cnt       = 0;

   function automatic logic [31:0] default_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : default_word(a);
   endfunction

   initial begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk); #2;
         mem_ack   = 1'b0;
         mem_rdata = $urandom;
         if (mem_req && !mem_silent) begin
            if (wait_cnt >= mem_delay) begin
               mem_ack   = 1'b1;
               mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : default_word(mem_addr);
               if (mem_we) mem_model[mem_addr] = mem_wdata;
               wait_cnt = 0;
               if (mem_rand_delay) mem_delay = $urandom_range(0, 4);
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr, input logic iabort,
                                input logic dreq, input logic dwe, input logic [31:0] daddr,
                                input logic [31:0] dwdata);
      if_req   = ireq;
      if_addr  = iaddr;
      if_abort = iabort;
      dm_req   = dreq;
      dm_we    = dwe;
      dm_addr  = daddr;
      dm_wdata = dwdata;
   endtask

   // Holds a data request until dm_valid (bounded) and checks the latency,
   // measured from the cycle the request is first presented.
   task automatic runDm(input string name, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int exp_lat, input bit chk_data,
                        input logic [31:0] exp_data);
      int lat = -1;
      for (int c = 0; c < 40 && lat < 0; c++) begin
         @(posedge clk); #1;
         applyStimulus(1'b0, '0, 1'b0, 1'b1, we, addr, wdata);
         #2;
         if (dm_valid) lat = c;
      end
      checkOutput({name, "_lat"}, lat, exp_lat);
      if (chk_data && lat >= 0) checkOutput({name, "_data"}, dm_rdata, exp_data);
      if (we && lat >= 0) ref_mem[addr] = wdata;
      @(posedge clk); #1;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   typedef struct {
      logic        ireq;
      logic [31:0] iaddr;
      logic        dreq;
      logic        dwe;
      logic [31:0] daddr;
      logic [31:0] dwdata;
      logic        e_mreq;
      logic        e_mwe;
      logic [31:0] e_maddr;
      logic        e_ivalid;
      logic [31:0] e_irdata;
      logic        e_dvalid;
      logic        e_istall;
      logic        e_dstall;
   } vec_t;

   vec_t        vecs [11];
   logic [31:0] exp_if_rdata;
   int          exp_order [6];

   // Random-phase requester and reference-model state
   bit          if_act, dm_act, abort_now;
   logic [31:0] r_iaddr, r_daddr, r_dwdata;
   logic        r_dwe;
   bit          p_idle, p_ireq, p_dreq, p_dwe, p_iabort, p_ack;
   logic [31:0] p_iaddr, p_daddr, p_dwdata;
   bit          m_busy, m_owner_dm, m_last_dm, m_abort;
   bit          g_dm, g_if, done_now, e_iv, e_dv;
   logic [31:0] e_maddr, e_mwdata;
   logic        e_mwe;

   initial begin
      // Zero-wait fetch then DM-first arbitration, one row per cycle
      vecs[0]  = '{1, 32'h40, 0, 0, 32'h0,   32'h0,    0, 0, 32'h0,   0, 32'h0,        0, 1, 0};
      vecs[1]  = '{1, 32'h40, 0, 0, 32'h0,   32'h0,    1, 0, 32'h40,  0, 32'h0,        0, 1, 0};
      vecs[2]  = '{1, 32'h40, 0, 0, 32'h0,   32'h0,    0, 0, 32'h0,   1, 32'h8C220004, 0, 0, 0};
      vecs[3]  = '{0, 32'h0,  0, 0, 32'h0,   32'h0,    0, 0, 32'h0,   0, 32'h8C220004, 0, 0, 0};
      vecs[4]  = '{1, 32'h44, 1, 1, 32'h100, 32'hDEAD, 0, 0, 32'h0,   0, 32'h8C220004, 0, 1, 1};
      vecs[5]  = '{1, 32'h44, 1, 1, 32'h100, 32'hDEAD, 1, 1, 32'h100, 0, 32'h8C220004, 0, 1, 1};
      vecs[6]  = '{1, 32'h44, 1, 1, 32'h100, 32'hDEAD, 0, 0, 32'h0,   0, 32'h8C220004, 1, 1, 0};
      vecs[7]  = '{1, 32'h44, 0, 0, 32'h0,   32'h0,    0, 0, 32'h0,   0, 32'h8C220004, 0, 1, 0};
      vecs[8]  = '{1, 32'h44, 0, 0, 32'h0,   32'h0,    1, 0, 32'h44,  0, 32'h8C220004, 0, 1, 0};
      vecs[9]  = '{1, 32'h44, 0, 0, 32'h0,   32'h0,    0, 0, 32'h0,   1, 32'h12345678, 0, 0, 0};
      vecs[10] = '{0, 32'h0,  0, 0, 32'h0,   32'h0,    0, 0, 32'h0,   0, 32'h12345678, 0, 0, 0};
      exp_order = '{1, 0, 1, 0, 1, 0};
      mem_model[32'h40] = 32'h8C220004;
      mem_model[32'h44] = 32'h12345678;

      // Reset values
      rst = 1'b1;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
      #1 rst = 1'b0;
      #2;
      checkOutput("rst_mem_req",   mem_req,   0);
      checkOutput("rst_mem_we",    mem_we,    0);
      checkOutput("rst_mem_addr",  mem_addr,  0);
      checkOutput("rst_mem_wdata", mem_wdata, 0);
      checkOutput("rst_if_valid",  if_valid,  0);
      checkOutput("rst_dm_valid",  dm_valid,  0);
      checkOutput("rst_if_rdata",  if_rdata,  0);
      checkOutput("rst_dm_rdata",  dm_rdata,  0);
      checkOutput("rst_arb_err",   arb_err,   0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Table-driven directed cycles
      mem_delay = 0;
      for (int i = 0; i < 11; i++) begin
         @(posedge clk); #1;
         applyStimulus(vecs[i].ireq, vecs[i].iaddr, 1'b0, vecs[i].dreq, vecs[i].dwe,
                       vecs[i].daddr, vecs[i].dwdata);
         #2;
         checkOutput($sformatf("vec%0d_mem_req", i),  mem_req,  vecs[i].e_mreq);
         if (vecs[i].e_mreq) begin
            checkOutput($sformatf("vec%0d_mem_we", i),   mem_we,   vecs[i].e_mwe);
            checkOutput($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].e_maddr);
         end
         checkOutput($sformatf("vec%0d_if_valid", i), if_valid, vecs[i].e_ivalid);
         checkOutput($sformatf("vec%0d_if_rdata", i), if_rdata, vecs[i].e_irdata);
         checkOutput($sformatf("vec%0d_dm_valid", i), dm_valid, vecs[i].e_dvalid);
         checkOutput($sformatf("vec%0d_if_stall", i), if_stall, vecs[i].e_istall);
         checkOutput($sformatf("vec%0d_dm_stall", i), dm_stall, vecs[i].e_dstall);
      end
      ref_mem[32'h100] = 32'hDEAD;

      // Both requesters held high: grants must alternate starting with DM
      begin
         int got = 0;
         for (int c = 0; c < 60 && got < 6; c++) begin
            @(posedge clk); #1;
            applyStimulus(1'b1, 32'h300, 1'b0, 1'b1, 1'b0, 32'h200, '0);
            #2;
            if (if_valid || dm_valid) begin
               checkOutput($sformatf("alt_order%0d", got), dm_valid, exp_order[got]);
               if (dm_valid) checkOutput("alt_dm_rdata", dm_rdata, ref_word(32'h200));
               else          checkOutput("alt_if_rdata", if_rdata, ref_word(32'h300));
               got++;
            end
         end
         checkOutput("alt_count", got, 6);
         @(posedge clk); #1;
         applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
         exp_if_rdata = ref_word(32'h300);
      end

      // Fetch aborted while in BUSY with a 4-cycle ack delay
      @(posedge clk);
      mem_delay = 4;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         applyStimulus(c < 3, 32'h80, c == 2, 1'b0, 1'b0, '0, '0);
         #2;
         checkOutput($sformatf("abort_c%0d_mem_req", c), mem_req, (c >= 1 && c <= 5));
         checkOutput($sformatf("abort_c%0d_if_valid", c), if_valid, 0);
         checkOutput($sformatf("abort_c%0d_if_rdata", c), if_rdata, exp_if_rdata);
      end
      mem_delay = 0;
      runDm("post_abort", 1'b0, 32'h84, '0, 2, 1'b1, ref_word(32'h84));

      // Reset in the middle of a DM access
      mem_delay = 3;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 32'h88, '0);
         #2;
      end
      checkOutput("midrst_busy_mem_req", mem_req, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      checkOutput("midrst_mem_req", mem_req, 0);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         checkOutput("midrst_hold_mem_req",  mem_req,  0);
         checkOutput("midrst_hold_dm_valid", dm_valid, 0);
         checkOutput("midrst_hold_dm_rdata", dm_rdata, 0);
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
      rst = 1'b1;
      mem_delay = 1;
      runDm("post_rst", 1'b0, 32'h8C, '0, 3, 1'b1, ref_word(32'h8C));

      // Randomized traffic against the transaction-level model; a reset pulse
      // first so the arbitration history starts at "last grant = IF".
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      mem_rand_delay = 1'b1;
      if_act = 0; dm_act = 0;
      p_idle = 1; p_ireq = 0; p_dreq = 0; p_dwe = 0; p_iabort = 0; p_ack = 0;
      p_iaddr = '0; p_daddr = '0; p_dwdata = '0;
      m_busy = 0; m_owner_dm = 0; m_last_dm = 0; m_abort = 0;
      e_maddr = '0; e_mwdata = '0; e_mwe = 1'b0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         @(posedge clk); #1;
         if (!if_act && $urandom_range(0, 2) == 0) begin
            if_act  = 1;
            r_iaddr = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
         end
         if (!dm_act && $urandom_range(0, 2) == 0) begin
            dm_act   = 1;
            r_daddr  = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
            r_dwe    = 1'($urandom_range(0, 1));
            r_dwdata = $urandom;
         end
         abort_now = if_act && ($urandom_range(0, 9) == 0);
         applyStimulus(if_act, r_iaddr, abort_now, dm_act, r_dwe, r_daddr, r_dwdata);
         #2;

         done_now = 0;
         if (m_busy) begin
            if (!m_owner_dm && p_iabort) m_abort = 1;
            if (p_ack) begin
               done_now = 1;
               m_busy   = 0;
            end
         end else if (p_idle) begin
            g_dm = p_dreq && (!p_ireq || !m_last_dm);
            g_if = !g_dm && p_ireq && !p_iabort;
            if (g_dm || g_if) begin
               m_busy     = 1;
               m_owner_dm = g_dm;
               m_last_dm  = g_dm;
               m_abort    = 0;
               e_maddr    = g_dm ? p_daddr : p_iaddr;
               e_mwe      = g_dm && p_dwe;
               e_mwdata   = p_dwdata;
            end
         end
         e_iv = done_now && !m_owner_dm && !m_abort;
         e_dv = done_now && m_owner_dm;

         checkOutput("rnd_mem_req",  mem_req,  m_busy);
         checkOutput("rnd_if_valid", if_valid, e_iv);
         checkOutput("rnd_dm_valid", dm_valid, e_dv);
         checkOutput("rnd_if_stall", if_stall, if_act && !e_iv);
         checkOutput("rnd_dm_stall", dm_stall, dm_act && !e_dv);
         if (m_busy) begin
            checkOutput("rnd_mem_addr", mem_addr, e_maddr);
            checkOutput("rnd_mem_we",   mem_we,   e_mwe);
            if (e_mwe) checkOutput("rnd_mem_wdata", mem_wdata, e_mwdata);
         end
         if (e_iv) checkOutput("rnd_if_rdata", if_rdata, ref_word(e_maddr));
         if (e_dv && !e_mwe) checkOutput("rnd_dm_rdata", dm_rdata, ref_word(e_maddr));
         if (e_dv && e_mwe) ref_mem[e_maddr] = e_mwdata;

         p_idle   = !m_busy && !done_now;
         p_ack    = mem_ack;
         p_ireq   = if_req;
         p_iaddr  = if_addr;
         p_iabort = if_abort;
         p_dreq   = dm_req;
         p_dwe    = dm_we;
         p_daddr  = dm_addr;
         p_dwdata = dm_wdata;
         if (if_valid || abort_now) if_act = 0;
         if (dm_valid) dm_act = 0;
      end
      @(posedge clk); #1;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
      mem_rand_delay = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      checkOutput("arb_err_clear", arb_err, 0);

`ifdef ARB_TIMEOUT_EN
      // Memory never acks: watchdog ends the access with all-ones data
      mem_silent = 1'b1;
      runDm("timeout", 1'b0, 32'h90, '0, 17, 1'b1, 32'hFFFFFFFF);
      checkOutput("timeout_arb_err", arb_err, 1);
      mem_silent = 1'b0;
      mem_delay  = 0;
      runDm("after_timeout", 1'b0, 32'h94, '0, 2, 1'b1, ref_word(32'h94));
      checkOutput("timeout_arb_err_sticky", arb_err, 1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port unified instruction/data memory between two requesters: the IF stage (instruction fetch, read-only) and the MEM stage (data load/store).
- Sequences each access with a request/acknowledge handshake to the memory, which has variable latency.
- Generates the IF and MEM stall signals that the hazard unit combines into its pcWrite, ifidWrite and stall_needed outputs.
- Sits between the pipeline datapath and the memory model, replacing the separate instruction and data memories.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- TIMEOUT, 15, watchdog limit in cycles per memory access; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch request; held until if_valid or if_abort.
- if_addr  in  AW  fetch address (PC).
- if_abort  in  1  pipeline flush; cancels the pending or in-flight fetch.
- if_rdata  out  DW  fetched instruction; registered.
- if_valid  out  1  one-cycle pulse; if_rdata is valid in this cycle.
- if_stall  out  1  if_req & ~if_valid (combinational).
- dm_req  in  1  data request; held until dm_valid.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  AW  data address.
- dm_wdata  in  DW  store data.
- dm_rdata  out  DW  load data; registered.
- dm_valid  out  1  one-cycle completion pulse (loads and stores).
- dm_stall  out  1  dm_req & ~dm_valid (combinational).
- mem_req  out  1  memory request; registered.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid when mem_ack = 1.
- mem_ack  in  1  one-cycle acknowledge from memory.
- arb_err  out  1  sticky timeout flag; only driven with ARB_TIMEOUT_EN.

Behaviour:
- Reset (rst = 0, asynchronous):
  - State goes to IDLE.
  - mem_req, mem_we, if_valid, dm_valid, arb_err all go to 0.
  - mem_addr, mem_wdata, if_rdata, dm_rdata go to 0.
  - last_grant goes to IF.
  - Reset asserted mid-access drops mem_req immediately; that access is abandoned and no valid pulse follows.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Grant goes to DM if dm_req = 1 and (if_req = 0 or last_grant = IF).
  - Otherwise grant goes to IF if if_req = 1 and if_abort = 0.
  - On a grant: latch owner, address, we and wdata into the mem_* registers, set mem_req = 1, go to BUSY, set last_grant = owner.
  - IF fetches always drive mem_we = 0.
  - With no request, stay in IDLE with mem_req = 0.
- BUSY:
  - mem_* outputs stay stable.
  - On mem_ack: mem_req goes to 0, mem_rdata is captured into the owner's rdata register, go to DONE.
- DONE:
  - Owner's valid = 1 for exactly this cycle, then go to IDLE.
  - Requests are not sampled in this cycle.
- Latency and throughput:
  - Request seen at edge N gives mem_req high after edge N.
  - mem_ack in cycle N+k gives valid in cycle N+k+1.
  - Minimum is 3 cycles per access, back-to-back.
- Alternation: when both requesters are continuously pending, grants alternate DM, IF, DM, IF, so neither starves.
- Abort:
  - if_abort while the IF access is in BUSY: the memory access completes normally, but if_valid is suppressed and if_rdata is not updated. The abort is latched until DONE.
  - if_abort in IDLE blocks an IF grant in that cycle.
  - if_abort never affects a DM access.
- Requests that change while not granted are ignored until IDLE.
- A mem_ack received while not in BUSY is ignored.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each cycle in BUSY.
  - When the count reaches TIMEOUT without mem_ack: mem_req goes to 0, the owner's valid pulses with rdata = all ones, arb_err is set sticky until reset, and the FSM goes to DONE.
- Undefined: no counter is built; BUSY waits indefinitely; arb_err is tied to 0.

Test Plan:
- Zero-wait memory (ack in the first mem_req cycle); if_req at cycle 0, if_addr = 0x40, mem_rdata = 0x8C220004 -> mem_req in cycle 1, if_valid in cycle 2 with if_rdata = 0x8C220004; if_stall = 1 in cycles 0-1.
- if_req and dm_req both at cycle 0, last_grant = IF, dm store of 0xDEAD to 0x100 -> DM is served first (mem_we = 1, mem_addr = 0x100, dm_valid in cycle 2); IF is granted in cycle 3 with if_valid in cycle 5.
- Both requesters held high for 6 accesses -> grant order is DM, IF, DM, IF, DM, IF.
- IF access in BUSY, 4-cycle ack delay, if_abort pulsed in cycle 2 -> mem_ack is consumed, no if_valid pulse, if_rdata unchanged, FSM returns to IDLE.
- rst dropped to 0 during BUSY -> mem_req = 0 immediately; after release, a fresh dm_req completes normally.
- With ARB_TIMEOUT_EN, TIMEOUT = 15, mem_ack never asserted -> owner's valid pulses in cycle 17 with rdata = 0xFFFFFFFF; arb_err = 1 and stays 1.
